// File: rtl/irq_controller.sv
// Priority interrupt controller: edge-detects the source lines, latches
// pending requests, gates them with a software mask and offers one vector at
// a time to the CPU through an ack / end-of-interrupt handshake. Edges that
// arrive on a source that is already pending are recorded as sticky overruns.
module irq_controller #(
    parameter int NIRQ = 7,
    parameter int VW   = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NIRQ-1:0] irq_in,
    input  logic            mask_we,
    input  logic [NIRQ-1:0] mask_in,
    output logic [NIRQ-1:0] mask_out,
    output logic            cpu_irq,
    output logic [VW-1:0]   cpu_vec,
    input  logic            cpu_ack,
    input  logic            cpu_eoi,
    output logic [NIRQ-1:0] pending,
    output logic [NIRQ-1:0] overrun,
    input  logic            ovr_clr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SERV = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [NIRQ-1:0] r_prev;
    logic [NIRQ-1:0] r_pending;
    logic [NIRQ-1:0] r_overrun;
    logic [NIRQ-1:0] r_mask;
    logic [VW-1:0]   r_sel;
    logic [VW-1:0]   w_sel_nxt;
    logic            r_cpu_irq;
    logic            w_irq_nxt;
    logic [VW-1:0]   r_cpu_vec;
    logic [VW-1:0]   w_vec_nxt;

    logic [NIRQ-1:0] w_edge;
    logic [NIRQ-1:0] w_active;
    logic [NIRQ-1:0] w_sel_oh;
    logic [NIRQ-1:0] w_clr;
    logic [NIRQ-1:0] w_ovr_set;
    logic [VW-1:0]   w_pick;
    logic            w_any;
    logic            w_ack_hit;
    logic            w_sel_en;

    assign w_edge    = irq_in & ~r_prev;
    assign w_active  = r_pending & r_mask;
    assign w_ack_hit = (r_state == REQ) && cpu_ack;
    // The edge wins over a same-cycle acknowledge, so an edge that lands on
    // the bit being cleared is a fresh request rather than an overrun.
    assign w_ovr_set = w_edge & r_pending & ~w_clr;
    assign w_sel_en  = |(r_mask & w_sel_oh);

    // Lowest-index enabled pending source wins arbitration.
    always_comb begin
        w_pick = '0;
        w_any  = 1'b0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_pick = VW'(i);
                w_any  = 1'b1;
            end
        end
    end

    // One-hot of the source in flight; also drives the pending clear on ack.
    always_comb begin
        w_sel_oh = '0;
        for (int i = 0; i < NIRQ; i++) begin
            w_sel_oh[i] = (r_sel == VW'(i));
        end
        w_clr = w_sel_oh & {NIRQ{w_ack_hit}};
    end

    // Next-state and next-output logic of the CPU handshake FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_irq_nxt   = r_cpu_irq;
        w_vec_nxt   = r_cpu_vec;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = REQ;
                    w_sel_nxt   = w_pick;
                    w_irq_nxt   = 1'b1;
                    w_vec_nxt   = w_pick + VW'(1);
                end
            end
            REQ: begin
                if (cpu_ack) begin
                    w_state_nxt = SERV;
                    w_irq_nxt   = 1'b0;
                end else if (!w_sel_en) begin
                    // Source masked after it was offered: withdraw the request.
                    w_state_nxt = IDLE;
                    w_irq_nxt   = 1'b0;
                    w_vec_nxt   = '0;
                end
            end
            SERV: begin
                if (cpu_eoi) begin
                    w_state_nxt = IDLE;
                    w_vec_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_irq_nxt   = 1'b0;
                w_vec_nxt   = '0;
            end
        endcase
    end

    // FSM state and registered CPU-facing outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_sel     <= '0;
            r_cpu_irq <= 1'b0;
            r_cpu_vec <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_sel     <= w_sel_nxt;
            r_cpu_irq <= w_irq_nxt;
            r_cpu_vec <= w_vec_nxt;
        end
    end

    // Edge history, pending latch, sticky overruns and the mask register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev    <= '0;
            r_pending <= '0;
            r_overrun <= '0;
            r_mask    <= '1;
        end else begin
            r_prev    <= irq_in;
            r_pending <= (r_pending & ~w_clr) | w_edge;
            r_overrun <= ovr_clr ? w_ovr_set : (r_overrun | w_ovr_set);
            if (mask_we) begin
                r_mask <= mask_in;
            end
        end
    end

    assign mask_out = r_mask;
    assign cpu_irq  = r_cpu_irq;
    assign cpu_vec  = r_cpu_vec;
    assign pending  = r_pending;
    assign overrun  = r_overrun;

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: a cycle-level reference model predicts the
// visible outputs after every clock edge and queues them; a monitor on the
// falling edge pops each prediction and compares it with the DUT. Directed
// scenarios are followed by a randomized phase.
module tb_irq_controller;

    localparam int NIRQ = 7;
    localparam int VW   = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [NIRQ-1:0] irq_in;
    logic            mask_we;
    logic [NIRQ-1:0] mask_in;
    logic [NIRQ-1:0] mask_out;
    logic            cpu_irq;
    logic [VW-1:0]   cpu_vec;
    logic            cpu_ack;
    logic            cpu_eoi;
    logic [NIRQ-1:0] pending;
    logic [NIRQ-1:0] overrun;
    logic            ovr_clr;

    always #5 clk = ~clk;

    irq_controller #(.NIRQ(NIRQ), .VW(VW)) dut (
        .clk      (clk),
        .rst      (rst),
        .irq_in   (irq_in),
        .mask_we  (mask_we),
        .mask_in  (mask_in),
        .mask_out (mask_out),
        .cpu_irq  (cpu_irq),
        .cpu_vec  (cpu_vec),
        .cpu_ack  (cpu_ack),
        .cpu_eoi  (cpu_eoi),
        .pending  (pending),
        .overrun  (overrun),
        .ovr_clr  (ovr_clr)
    );

    typedef struct {
        logic            irq;
        logic [VW-1:0]   vec;
        logic [NIRQ-1:0] pend;
        logic [NIRQ-1:0] ovr;
        logic [NIRQ-1:0] mask;
    } exp_t;

    exp_t q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Per-source flags plus "which vector is out" and "has the CPU taken it".
    bit m_pend[NIRQ];
    bit m_ovr[NIRQ];
    bit m_msk[NIRQ];
    bit m_prev[NIRQ];
    int m_vec;      // 0 = nothing offered or in service, else source+1
    bit m_offer;    // vector currently requested from the CPU
    bit m_serv;     // vector taken, awaiting end of interrupt

    function automatic exp_t snap();
        exp_t e;
        e.irq = m_offer;
        e.vec = VW'(m_vec);
        for (int i = 0; i < NIRQ; i++) begin
            e.pend[i] = m_pend[i];
            e.ovr[i]  = m_ovr[i];
            e.mask[i] = m_msk[i];
        end
        return e;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        int hit;
        int lo;
        bit e_i;
        bit c_i;
        bit s_i;
        if (rst) begin
            for (int i = 0; i < NIRQ; i++) begin
                m_pend[i] = 1'b0;
                m_ovr[i]  = 1'b0;
                m_msk[i]  = 1'b1;
                m_prev[i] = 1'b0;
            end
            m_vec   = 0;
            m_offer = 1'b0;
            m_serv  = 1'b0;
            q.delete();
            q.push_back(snap());
        end else begin
            hit = (m_offer && cpu_ack) ? m_vec - 1 : -1;
            if (m_vec == 0) begin
                lo = -1;
                for (int i = NIRQ - 1; i >= 0; i--) begin
                    if (m_pend[i] && m_msk[i]) lo = i;
                end
                if (lo >= 0) begin
                    m_vec   = lo + 1;
                    m_offer = 1'b1;
                end
            end else if (m_offer) begin
                if (cpu_ack) begin
                    m_offer = 1'b0;
                    m_serv  = 1'b1;
                end else if (!m_msk[m_vec - 1]) begin
                    m_offer = 1'b0;
                    m_vec   = 0;
                end
            end else if (m_serv) begin
                if (cpu_eoi) begin
                    m_serv = 1'b0;
                    m_vec  = 0;
                end
            end
            for (int i = 0; i < NIRQ; i++) begin
                e_i       = irq_in[i] && !m_prev[i];
                c_i       = (i == hit);
                s_i       = e_i && m_pend[i] && !c_i;
                m_pend[i] = e_i || (m_pend[i] && !c_i);
                m_ovr[i]  = s_i || (m_ovr[i] && !ovr_clr);
                m_prev[i] = irq_in[i];
                if (mask_we) m_msk[i] = mask_in[i];
            end
            q.push_back(snap());
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("cpu_irq",  32'(cpu_irq),  32'(e.irq));
            check("cpu_vec",  32'(cpu_vec),  32'(e.vec));
            check("pending",  32'(pending),  32'(e.pend));
            check("overrun",  32'(overrun),  32'(e.ovr));
            check("mask_out", 32'(mask_out), 32'(e.mask));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic pulse_irq(input logic [NIRQ-1:0] v);
        irq_in = v;
        tick();
        irq_in = '0;
    endtask

    task automatic write_mask(input logic [NIRQ-1:0] v);
        mask_in = v;
        mask_we = 1'b1;
        tick();
        mask_we = 1'b0;
    endtask

    task automatic ack();
        cpu_ack = 1'b1;
        tick();
        cpu_ack = 1'b0;
    endtask

    task automatic eoi();
        cpu_eoi = 1'b1;
        tick();
        cpu_eoi = 1'b0;
    endtask

    task automatic wait_irq(input string name, input int budget);
        int k;
        k = 0;
        while (!cpu_irq && k < budget) begin
            tick();
            k++;
        end
        if (!cpu_irq) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: cpu_irq still 0 after %0d cycles, expected 1", name, budget);
        end
    endtask

    task automatic serve(input string name);
        wait_irq(name, 10);
        ack();
        tick();
        eoi();
        tick();
    endtask

    initial begin
        rst     = 1'b1;
        irq_in  = '0;
        mask_we = 1'b0;
        mask_in = '1;
        cpu_ack = 1'b0;
        cpu_eoi = 1'b0;
        ovr_clr = 1'b0;
        ticks(3);
        rst = 1'b0;
        tick();

        // Single request on source 2.
        pulse_irq(7'b0000100);
        tick();
        serve("single_src2");

        // Two simultaneous requests: 1 then 6.
        pulse_irq(7'b1000010);
        serve("prio_first");
        serve("prio_second");

        // Masked source still latches, released by a mask write.
        write_mask(7'b1111011);
        pulse_irq(7'b0000100);
        ticks(4);
        write_mask(7'b1111111);
        serve("unmask_src2");

        // Double edge on source 4 before ack gives an overrun.
        pulse_irq(7'b0010000);
        tick();
        pulse_irq(7'b0010000);
        tick();
        serve("overrun_src4");
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        tick();

        // New edge on source 0 in the same cycle as its ack.
        pulse_irq(7'b0000001);
        wait_irq("edge_vs_ack", 10);
        irq_in  = 7'b0000001;
        cpu_ack = 1'b1;
        tick();
        irq_in  = '0;
        cpu_ack = 1'b0;
        tick();
        eoi();
        serve("edge_vs_ack_second");

        // Build up state, then reset asynchronously while in service.
        write_mask(7'b0111111);
        pulse_irq(7'b1000000);
        tick();
        pulse_irq(7'b1000000);
        pulse_irq(7'b0001000);
        wait_irq("pre_reset", 10);
        ack();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst cpu_irq",  32'(cpu_irq),  32'h0);
        check("async_rst cpu_vec",  32'(cpu_vec),  32'h0);
        check("async_rst pending",  32'(pending),  32'h0);
        check("async_rst overrun",  32'(overrun),  32'h0);
        check("async_rst mask_out", 32'(mask_out), 32'h7f);
        @(posedge clk);
        #1;
        rst = 1'b0;
        eoi();
        ticks(2);

        // Randomized traffic.
        for (int c = 0; c < 2000; c++) begin
            irq_in  = NIRQ'($urandom) & NIRQ'($urandom) & NIRQ'($urandom);
            cpu_ack = ($urandom_range(0, 3) == 0);
            cpu_eoi = ($urandom_range(0, 3) == 0);
            ovr_clr = ($urandom_range(0, 19) == 0);
            mask_we = ($urandom_range(0, 19) == 0);
            mask_in = NIRQ'($urandom) | NIRQ'($urandom);
            tick();
        end
        irq_in  = '0;
        cpu_ack = 1'b0;
        cpu_eoi = 1'b0;
        ovr_clr = 1'b0;
        mask_we = 1'b0;
        ticks(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
